// File: rtl/uart_tl_bridge_q.sv
// uart_tl_bridge_q: queues 16-byte host packets from the UART client and presents
// the head entry as TileLink frame fields to GenericSerializer, handshaking on
// edges of the slower tl_clk. Optional head-drop timeout via UART_TL_BRIDGE_TIMEOUT_EN.
`timescale 1ns/1ps
module uart_tl_bridge_q #(
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter int unsigned ADDR_W        = 64,
    parameter logic [7:0]  SRC_ID        = 8'h00,
    parameter int unsigned TIMEOUT_EDGES = 1024
) (
    input  logic                         sysclk,
    input  logic                         reset,
    input  logic                         tl_clk,
    input  logic                         packet_valid,
    output logic                         packet_ready,
    input  logic [127:0]                 packet_data,
    output logic                         tl_ser_in_valid,
    input  logic                         tl_ser_in_ready,
    output logic [2:0]                   tl_in_bits_chanId,
    output logic [2:0]                   tl_in_bits_opcode,
    output logic [2:0]                   tl_in_bits_param,
    output logic [7:0]                   tl_in_bits_size,
    output logic [7:0]                   tl_in_bits_source,
    output logic [ADDR_W-1:0]            tl_in_bits_address,
    output logic [63:0]                  tl_in_bits_data,
    output logic                         tl_in_bits_corrupt,
    output logic [8:0]                   tl_in_bits_union,
    output logic                         tl_in_bits_last,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
    output logic [15:0]                  drop_count,
    output logic                         busy
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_PRESENT, ST_GAP} state_t;

    state_t            state, state_next;
    logic              tl_s1, tl_s2, tl_s3, rdy_s1, rdy_s2;
    logic              tl_rise, tl_fall;
    logic [127:0]      mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [LVL_W-1:0]  count, count_next;
    logic [127:0]      frame_q;
    logic              accept, push, drop_in, fifo_empty;
    logic              pop, timeout, to_hit;
    logic [1:0]        drop_inc;
    logic [16:0]       drop_sum;
    logic              unused_frame_bits;

    // Two-flop synchronisers plus one history flop for edge detection
    always_ff @(posedge sysclk) begin
        if (reset) begin
            tl_s1  <= 1'b0;
            tl_s2  <= 1'b0;
            tl_s3  <= 1'b0;
            rdy_s1 <= 1'b0;
            rdy_s2 <= 1'b0;
        end else begin
            tl_s1  <= tl_clk;
            tl_s2  <= tl_s1;
            tl_s3  <= tl_s2;
            rdy_s1 <= tl_ser_in_ready;
            rdy_s2 <= rdy_s1;
        end
    end

    assign tl_rise    = tl_s2 & ~tl_s3;
    assign tl_fall    = ~tl_s2 & tl_s3;
    assign accept     = packet_valid & packet_ready;
    assign push       = accept & (packet_data[2:0] == 3'd0);
    assign drop_in    = accept & (packet_data[2:0] != 3'd0);
    assign fifo_empty = (count == LVL_W'(0));
    assign count_next = count + LVL_W'(push) - LVL_W'(pop);

`ifdef UART_TL_BRIDGE_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_EDGES + 1);
    logic [CNT_W-1:0] edge_cnt;

    // Counts tl_rise edges seen while a frame waits in PRESENT
    always_ff @(posedge sysclk) begin
        if (reset) begin
            edge_cnt <= '0;
        end else if (pop) begin
            edge_cnt <= '0;
        end else if (state == ST_PRESENT && tl_rise) begin
            edge_cnt <= edge_cnt + CNT_W'(1);
        end
    end

    assign to_hit = (edge_cnt == CNT_W'(TIMEOUT_EDGES - 1));
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_EDGES != 0);
    assign to_hit         = 1'b0;
`endif

    // Output FSM state register
    always_ff @(posedge sysclk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Output FSM next-state: pop on tl_fall, complete on tl_rise with ready
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        timeout    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (tl_fall && !fifo_empty) begin
                    pop        = 1'b1;
                    state_next = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                if (tl_rise) begin
                    if (rdy_s2) begin
                        state_next = ST_GAP;
                    end else if (to_hit) begin
                        timeout    = 1'b1;
                        state_next = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (tl_fall) begin
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        state_next = ST_PRESENT;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Packet storage
    always_ff @(posedge sysclk) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr] <= packet_data;
        end
    end

    assign drop_inc = {1'b0, drop_in} + {1'b0, timeout};
    assign drop_sum = 17'(drop_count) + 17'(drop_inc);

    // Pointers, occupancy, output register and status outputs
    always_ff @(posedge sysclk) begin
        if (reset) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count           <= '0;
            frame_q         <= '0;
            packet_ready    <= 1'b1;
            tl_ser_in_valid <= 1'b0;
            busy            <= 1'b0;
            drop_count      <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                frame_q <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + PTR_W'(1);
            end
            count           <= count_next;
            packet_ready    <= (count_next != LVL_W'(FIFO_DEPTH));
            tl_ser_in_valid <= (state_next == ST_PRESENT);
            busy            <= (count_next != LVL_W'(0)) || (state_next != ST_IDLE);
            drop_count      <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end

    assign fifo_level         = count;
    assign tl_in_bits_chanId  = frame_q[2:0];
    assign tl_in_bits_opcode  = frame_q[10:8];
    assign tl_in_bits_param   = frame_q[14:12];
    assign tl_in_bits_corrupt = frame_q[15];
    assign tl_in_bits_size    = frame_q[23:16];
    assign tl_in_bits_union   = {1'b0, frame_q[31:24]};
    assign tl_in_bits_address = ADDR_W'(frame_q[63:32]);
    assign tl_in_bits_data    = frame_q[127:64];
    assign tl_in_bits_source  = SRC_ID;
    assign tl_in_bits_last    = 1'b1;
    assign unused_frame_bits  = ^{frame_q[7:3], frame_q[11]};

endmodule

// File: tb/tb_uart_tl_bridge_q.sv
// Bench for uart_tl_bridge_q: directed packets, a queue model of expected frames,
// and a per-cycle compare process that checks presented frames and handshakes.
`timescale 1ns/1ps
module tb_uart_tl_bridge_q;

    localparam int unsigned DEPTH    = 4;
    localparam logic [7:0]  SRC      = 8'h5A;
    localparam int unsigned TO_EDGES = 8;

    typedef struct {
        logic [7:0]  b0;
        logic [2:0]  opc;
        logic [2:0]  prm;
        logic        cor;
        logic        rsv;
        logic [7:0]  sz;
        logic [7:0]  mk;
        logic [31:0] ad;
        logic [63:0] dt;
    } vec_t;

    logic          sysclk = 1'b0;
    logic          reset = 1'b1;
    logic          tl_clk = 1'b0;
    logic          packet_valid = 1'b0;
    logic [127:0]  packet_data = '0;
    logic          tl_ser_in_ready = 1'b0;
    logic          packet_ready, tl_ser_in_valid;
    logic [2:0]    tl_in_bits_chanId, tl_in_bits_opcode, tl_in_bits_param;
    logic [7:0]    tl_in_bits_size, tl_in_bits_source;
    logic [63:0]   tl_in_bits_address, tl_in_bits_data;
    logic          tl_in_bits_corrupt, tl_in_bits_last;
    logic [8:0]    tl_in_bits_union;
    logic [2:0]    fifo_level;
    logic [15:0]   drop_count;
    logic          busy;

    int            total = 0;
    int            bad = 0;
    logic [191:0]  exp_q [$];
    int            delivered = 0;
    int            to_drops = 0;
    int            rises = 0;
    int            ok_cnt = 0;
    int            last_rises = 0;
    logic          ready_val = 1'b0;
    logic          rdy_alt = 1'b0;
    logic          prev_valid = 1'b0;
    logic [191:0]  held = '0;
    logic [191:0]  act = '0;

    uart_tl_bridge_q #(
        .FIFO_DEPTH(DEPTH), .ADDR_W(64), .SRC_ID(SRC), .TIMEOUT_EDGES(TO_EDGES)
    ) dut (
        .sysclk(sysclk), .reset(reset), .tl_clk(tl_clk),
        .packet_valid(packet_valid), .packet_ready(packet_ready), .packet_data(packet_data),
        .tl_ser_in_valid(tl_ser_in_valid), .tl_ser_in_ready(tl_ser_in_ready),
        .tl_in_bits_chanId(tl_in_bits_chanId), .tl_in_bits_opcode(tl_in_bits_opcode),
        .tl_in_bits_param(tl_in_bits_param), .tl_in_bits_size(tl_in_bits_size),
        .tl_in_bits_source(tl_in_bits_source), .tl_in_bits_address(tl_in_bits_address),
        .tl_in_bits_data(tl_in_bits_data), .tl_in_bits_corrupt(tl_in_bits_corrupt),
        .tl_in_bits_union(tl_in_bits_union), .tl_in_bits_last(tl_in_bits_last),
        .fifo_level(fifo_level), .drop_count(drop_count), .busy(busy)
    );

    always #5 sysclk = ~sysclk;

    // tl_clk = sysclk/8; ready changes only on tl falls and is recorded at tl rises
    initial begin
        forever begin
            repeat (4) @(negedge sysclk);
            tl_clk = ~tl_clk;
            if (tl_clk) begin
                rises++;
                if (tl_ser_in_ready) ok_cnt++;
            end else begin
                tl_ser_in_ready = rdy_alt ? ~tl_ser_in_ready : ready_val;
            end
        end
    end

    task automatic chk(input string nm, input logic [191:0] a, input logic [191:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, a, e);
        end
    endtask

    task automatic fail_now(input string nm, input int a, input int e);
        total++;
        bad++;
        $display("FAIL %s actual=%0d required=%0d", nm, a, e);
    endtask

    function automatic logic [191:0] cur_frame();
        return 192'({tl_in_bits_chanId, tl_in_bits_opcode, tl_in_bits_param, tl_in_bits_size,
                     tl_in_bits_address, tl_in_bits_data, tl_in_bits_corrupt, tl_in_bits_union,
                     tl_in_bits_source, tl_in_bits_last});
    endfunction

    function automatic logic [191:0] exp_frame(input vec_t v);
        return 192'({3'd0, v.opc, v.prm, v.sz, {32'h0, v.ad}, v.dt, v.cor, {1'b0, v.mk},
                     SRC, 1'b1});
    endfunction

    function automatic vec_t vec(input int i);
        vec_t v;
        v.b0  = 8'(i * 8);
        v.opc = 3'(i);
        v.prm = 3'(i + 3);
        v.cor = i[0];
        v.rsv = i[1];
        v.sz  = 8'(i * 3);
        v.mk  = 8'(255 - i);
        v.ad  = 32'h8000_0000 | 32'(i << 4);
        v.dt  = {32'(i * 32'h0101_0101), 32'hCAFE_0000 | 32'(i)};
        return v;
    endfunction

    // Offer one packet once the bridge can take it; chan0 packets join the model queue
    task automatic push(input vec_t v);
        int n = 0;
        while (packet_ready !== 1'b1 && n < 500) begin
            @(posedge sysclk); #1;
            n++;
        end
        if (packet_ready !== 1'b1) begin
            fail_now("push_wait_cycles", n, 500);
        end else begin
            packet_data  = {v.dt, v.ad, v.mk, v.sz, v.cor, v.prm, v.rsv, v.opc, v.b0};
            packet_valid = 1'b1;
            @(posedge sysclk); #1;
            packet_valid = 1'b0;
            if (v.b0[2:0] == 3'd0) exp_q.push_back(exp_frame(v));
        end
    endtask

    task automatic wait_valid(input string nm);
        int n = 0;
        while (tl_ser_in_valid !== 1'b1 && n < 300) begin
            @(posedge sysclk); #1;
            n++;
        end
        if (tl_ser_in_valid !== 1'b1) fail_now(nm, n, 300);
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while ((exp_q.size() != 0 || busy !== 1'b0) && n < 3000) begin
            @(posedge sysclk); #1;
            n++;
        end
        total++;
        if (n >= 3000) begin
            bad++;
            $display("FAIL %s actual=%0d required=idle", nm, exp_q.size());
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge sysclk);
        #1;
    endtask

    // Per-cycle frame check against the model queue
    always begin
        @(posedge sysclk); #1;
        if (reset) begin
            exp_q.delete();
            prev_valid = 1'b0;
        end else begin
            if (tl_ser_in_valid) begin
                act = cur_frame();
                if (!prev_valid) begin
                    chk("frame_rise_tl_low", 192'(tl_clk), 192'(0));
                    ok_cnt = 0;
                    rises  = 0;
                    held   = act;
                end else begin
                    chk("frame_hold", act, held);
                end
                if (exp_q.size() == 0) fail_now("unexpected_frame", 0, 1);
                else chk("frame_fields", act, exp_q[0]);
            end else if (prev_valid) begin
                if (ok_cnt > 0) begin
                    chk("ready_rises_in_frame", 192'(ok_cnt), 192'(1));
                    last_rises = rises;
                    delivered++;
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                end else begin
`ifdef UART_TL_BRIDGE_TIMEOUT_EN
                    chk("timeout_rises", 192'(rises), 192'(TO_EDGES));
                    to_drops++;
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
`else
                    fail_now("frame_dropped_without_ready", rises, 0);
`endif
                end
            end
            prev_valid = tl_ser_in_valid;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog_timeout actual=%0d required=finished", delivered);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        // Reset state
        repeat (3) @(posedge sysclk);
        #1;
        chk("rst_valid", 192'(tl_ser_in_valid), 192'(0));
        chk("rst_ready", 192'(packet_ready), 192'(1));
        chk("rst_level", 192'(fifo_level), 192'(0));
        chk("rst_drops", 192'(drop_count), 192'(0));
        chk("rst_busy", 192'(busy), 192'(0));
        chk("rst_frame", cur_frame(), 192'({155'd0, SRC, 1'b1}));
        @(negedge sysclk);
        reset     = 1'b0;
        ready_val = 1'b1;
        wait_cycles(20);

        // T1: single packet, literal field expectations
        v.b0 = 8'h00; v.opc = 3'd4; v.prm = 3'd0; v.cor = 1'b0; v.rsv = 1'b0;
        v.sz = 8'd3; v.mk = 8'hFF; v.ad = 32'h8000_1000; v.dt = 64'h1122_3344_5566_7788;
        push(v);
        wait_valid("t1_valid_wait");
        chk("t1_addr", 192'(tl_in_bits_address), 192'(64'h0000_0000_8000_1000));
        chk("t1_union", 192'(tl_in_bits_union), 192'(9'h0FF));
        chk("t1_opcode", 192'(tl_in_bits_opcode), 192'(3'd4));
        chk("t1_size", 192'(tl_in_bits_size), 192'(8'd3));
        chk("t1_data", 192'(tl_in_bits_data), 192'(64'h1122_3344_5566_7788));
        chk("t1_source", 192'(tl_in_bits_source), 192'(8'h5A));
        chk("t1_last", 192'(tl_in_bits_last), 192'(1));
        wait_idle("t1_idle");
        chk("t1_delivered", 192'(delivered), 192'(1));
        chk("t1_one_rise", 192'(last_rises), 192'(1));

        // T3: illegal channel dropped, next chan0 packet delivered
        v = vec(5);
        v.b0 = 8'h03;
        push(v);
        chk("t3_drop_count", 192'(drop_count), 192'(1));
        push(vec(10));
        wait_idle("t3_idle");
        chk("t3_delivered", 192'(delivered), 192'(2));
        chk("t3_drop_hold", 192'(drop_count), 192'(1));

        // T2: burst of 6 against a stalled serializer
        ready_val = 1'b0;
        wait_cycles(20);
        push(vec(20));
        wait_valid("t2_valid_wait");
        for (int i = 21; i <= 24; i++) push(vec(i));
        chk("t2_level_full", 192'(fifo_level), 192'(4));
        chk("t2_ready_low", 192'(packet_ready), 192'(0));
        chk("t2_busy", 192'(busy), 192'(1));
        ready_val = 1'b1;
        push(vec(25));
        wait_idle("t2_idle");
        chk("t2_delivered", 192'(delivered), 192'(8));

        // T4: ready alternating on every tl fall
        rdy_alt = 1'b1;
        for (int i = 26; i <= 28; i++) push(vec(i));
        wait_idle("t4_idle");
        chk("t4_delivered", 192'(delivered), 192'(11));
        rdy_alt   = 1'b0;
        ready_val = 1'b0;
        wait_cycles(20);

        // T5: reset while presenting with 3 queued
        push(vec(29));
        wait_valid("t5_valid_wait");
        for (int i = 30; i <= 32; i++) push(vec(i));
        chk("t5_level", 192'(fifo_level), 192'(3));
        reset = 1'b1;
        @(posedge sysclk); #1;
        chk("t5_valid", 192'(tl_ser_in_valid), 192'(0));
        chk("t5_level_clr", 192'(fifo_level), 192'(0));
        chk("t5_ready", 192'(packet_ready), 192'(1));
        chk("t5_drops_clr", 192'(drop_count), 192'(0));
        @(negedge sysclk);
        reset     = 1'b0;
        ready_val = 1'b1;
        wait_cycles(64);
        chk("t5_nothing_after", 192'(delivered), 192'(11));
        chk("t5_valid_idle", 192'(tl_ser_in_valid), 192'(0));

`ifdef UART_TL_BRIDGE_TIMEOUT_EN
        // T6: timeout drops head after TO_EDGES rises, next frame follows
        ready_val = 1'b0;
        wait_cycles(20);
        push(vec(33));
        wait_valid("t6_valid_wait");
        push(vec(34));
        begin
            int n = 0;
            while (to_drops == 0 && n < 300) begin
                @(posedge sysclk); #1;
                n++;
            end
        end
        chk("t6_timeout_seen", 192'(to_drops), 192'(1));
        chk("t6_drop_count", 192'(drop_count), 192'(1));
        wait_valid("t6_next_valid");
        ready_val = 1'b1;
        wait_idle("t6_idle");
        chk("t6_delivered", 192'(delivered), 192'(12));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
